// File: rtl/drum_envelope.sv
// drum_envelope: attack/hold/decay amplitude envelope that scales offset-binary
// samples on each sample_tick, with a two-stage multiply pipeline to the DAC.
module drum_envelope #(
   parameter int HOLD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
   input  logic                  sample_tick,
   input  logic [15:0]           sample_in,
   input  logic [15:0]           attack_step,
   input  logic [HOLD_WIDTH-1:0] hold_samples,
   input  logic [3:0]            decay_shift,
   output logic [15:0]           sample_out,
   output logic                  sample_out_valid,
   output logic [15:0]           env_level,
   output logic                  active
);
   typedef enum logic [1:0] {IDLE, ATTACK, HOLD, DECAY} state_t;
   state_t                state_q, state_d;
   logic [15:0]           env_q, env_d;
   logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
   logic [15:0]           p_q, p_d;
   logic                  v1_q;
   logic [15:0]           out_q, out_d;
   logic                  vld_q;
   logic [16:0]           sum;
   logic [16:0]           step;
   logic signed [15:0]    c;
   logic signed [32:0]    prod;
   always_comb begin
      sum = {1'b0, env_q} + {1'b0, attack_step};
      step = {1'b0, env_q >> decay_shift} + 17'd1;
      state_d = state_q;
      env_d = env_q;
      cnt_d = cnt_q;
      if (trigger) begin
         state_d = (attack_step == 16'd0) ? HOLD : ATTACK;
         env_d = (attack_step == 16'd0) ? 16'hFFFF : env_q;
         cnt_d = (attack_step == 16'd0) ? hold_samples : cnt_q;
      end else if (sample_tick) begin
         case (state_q)
            ATTACK: begin
               state_d = (sum >= 17'h0FFFF) ? HOLD : ATTACK;
               env_d = (sum >= 17'h0FFFF) ? 16'hFFFF : sum[15:0];
               cnt_d = (sum >= 17'h0FFFF) ? hold_samples : cnt_q;
            end
            HOLD: begin
               state_d = (cnt_q == '0) ? DECAY : HOLD;
               cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - HOLD_WIDTH'(1);
            end
            DECAY: begin
               state_d = ({1'b0, env_q} <= step) ? IDLE : DECAY;
               env_d = ({1'b0, env_q} <= step) ? 16'd0 : env_q - step[15:0];
            end
            default: env_d = 16'd0;
         endcase
      end
      // stage 1 uses the level before this cycle's envelope update
      c = sample_in ^ 16'h8000;
      prod = 33'(c) * 33'($signed({1'b0, env_q}));
      p_d = sample_tick ? 16'(prod >>> 16) : p_q;
      out_d = v1_q ? (p_q ^ 16'h8000) : out_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         env_q <= 16'd0;
         cnt_q <= '0;
         p_q <= 16'd0;
         v1_q <= 1'b0;
         out_q <= 16'h8000;
         vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         env_q <= env_d;
         cnt_q <= cnt_d;
         p_q <= p_d;
         v1_q <= sample_tick;
         out_q <= out_d;
         vld_q <= v1_q;
      end
   end
   assign sample_out = out_q;
   assign sample_out_valid = vld_q;
   assign env_level = env_q;
   assign active = (state_q != IDLE);
endmodule

// File: tb/tb_drum_envelope.sv
// tb_drum_envelope: directed vector table plus randomized traffic, all checked
// against an integer-arithmetic envelope model with a queue for the output pipeline.
module tb_drum_envelope;
   logic        clk = 1'b0;
   logic        rst, trigger, sample_tick;
   logic [15:0] sample_in, attack_step;
   logic [15:0] hold_samples;
   logic [3:0]  decay_shift;
   logic [15:0] sample_out, env_level;
   logic        sample_out_valid, active;

   drum_envelope #(.HOLD_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .sample_tick(sample_tick),
      .sample_in(sample_in), .attack_step(attack_step), .hold_samples(hold_samples),
      .decay_shift(decay_shift), .sample_out(sample_out),
      .sample_out_valid(sample_out_valid), .env_level(env_level), .active(active)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_ATTACK = 1, M_HOLD = 2, M_DECAY = 3;
   typedef struct {int due; int val;} pend_t;
   typedef struct {logic trig; logic tick; logic [15:0] sin; logic [15:0] env; logic act;} vec_t;

   int    checks = 0, failures = 0, cyc = 0;
   int    ms = M_IDLE, menv = 0, mcnt = 0, mout = 32768;
   logic  mvalid = 1'b0;
   pend_t pq[$];
   vec_t  tbl[11];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int scale(input int s, input int e);
      longint p, q;
      p = longint'(s - 32768) * e;
      q = (p >= 0) ? p / 65536 : -((-p + 65535) / 65536);
      return int'(q) + 32768;
   endfunction

   task automatic cycle(input logic r, input logic t, input logic k, input logic [15:0] s);
      int st;
      rst = r; trigger = t; sample_tick = k; sample_in = s;
      @(posedge clk);
      cyc++;
      mvalid = 1'b0;
      if (!r) begin
         ms = M_IDLE; menv = 0; mcnt = 0; mout = 32768; pq.delete();
      end else begin
         if (pq.size() > 0 && pq[0].due == cyc) begin
            mvalid = 1'b1; mout = pq[0].val; void'(pq.pop_front());
         end
         if (k) pq.push_back('{cyc + 1, scale(int'(s), menv)});
         if (t) begin
            if (attack_step == 0) begin ms = M_HOLD; menv = 65535; mcnt = hold_samples; end
            else ms = M_ATTACK;
         end else if (k) begin
            if (ms == M_ATTACK) begin
               if (menv + attack_step >= 65535) begin ms = M_HOLD; menv = 65535; mcnt = hold_samples; end
               else menv = menv + attack_step;
            end else if (ms == M_HOLD) begin
               if (mcnt == 0) ms = M_DECAY; else mcnt--;
            end else if (ms == M_DECAY) begin
               st = menv / (1 << decay_shift) + 1;
               if (menv <= st) begin menv = 0; ms = M_IDLE; end
               else menv = menv - st;
            end
         end
      end
      #1;
      chk("env_level", env_level, menv);
      chk("active", active, ms != M_IDLE);
      chk("sample_out_valid", sample_out_valid, mvalid);
      chk("sample_out", sample_out, mout);
   endtask

   initial begin
      int n, pick, st, r;
      rst = 1'b0; trigger = 1'b0; sample_tick = 1'b0; sample_in = 16'h8000;
      attack_step = 16'h4000; hold_samples = 16'd2; decay_shift = 4'd4;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'(i % 2 == 0), 16'hFFFF);
         chk("rst_out", sample_out, 16'h8000);
         chk("rst_env", env_level, 0);
      end

      tbl[0]  = '{1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 16'hC000, 16'h4000, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 16'h1111, 16'h4000, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'h8000, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 16'hFFFF, 16'hC000, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 16'h7000, 16'hFFFF, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 16'h9000, 16'hFFFF, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 16'hC000, 16'hFFFF, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 16'h2345, 16'hFFFF, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 16'hABCD, 16'hEFFF, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 16'h8000, 16'hE0FF, 1'b1};
      foreach (tbl[i]) begin
         cycle(1'b1, tbl[i].trig, tbl[i].tick, tbl[i].sin);
         chk("tbl_env", env_level, tbl[i].env);
         chk("tbl_active", active, tbl[i].act);
      end

      n = 0;
      while (menv != 0 && n < 5000) begin cycle(1'b1, 1'b0, 1'b1, 16'($urandom)); n++; end
      chk("decay_end_env", env_level, 0);
      chk("decay_end_active", active, 0);
      cycle(1'b1, 1'b0, 1'b1, 16'h1234);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("zero_env_valid", sample_out_valid, 1);
      chk("zero_env_out", sample_out, 16'h8000);

      attack_step = 16'h0000; hold_samples = 16'd20;
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("instant_env", env_level, 16'hFFFF);
      cycle(1'b1, 1'b0, 1'b1, 16'hC000);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      chk("scale_c000_v", sample_out_valid, 1);
      chk("scale_c000", sample_out, 16'hBFFF);
      cycle(1'b1, 1'b0, 1'b1, 16'hFFFF);
      chk("scale_0000_v", sample_out_valid, 1);
      chk("scale_0000", sample_out, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("scale_ffff_v", sample_out_valid, 1);
      chk("scale_ffff", sample_out, 16'hFFFE);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("scale_idle_v", sample_out_valid, 0);
      chk("scale_hold_out", sample_out, 16'hFFFE);

      hold_samples = 16'd0;
      cycle(1'b1, 1'b1, 1'b0, 16'h8000);
      cycle(1'b1, 1'b0, 1'b1, 16'h8000);
      n = 0;
      while (menv != 16'h9000 && n < 300) begin
         pick = 15;
         for (int s = 15; s >= 0; s--) begin
            st = menv / (1 << s) + 1;
            r = menv - st - 16'h9000;
            if (r == 0 || r >= 2) pick = s;
         end
         decay_shift = 4'(pick);
         cycle(1'b1, 1'b0, 1'b1, 16'($urandom));
         n++;
      end
      chk("pre_retrig_env", env_level, 16'h9000);
      attack_step = 16'h1000;
      cycle(1'b1, 1'b1, 1'b1, 16'h4000);
      chk("retrig_env", env_level, 16'h9000);
      chk("retrig_active", active, 1);
      cycle(1'b1, 1'b0, 1'b1, 16'h4000);
      chk("retrig_step", env_level, 16'hA000);
      attack_step = 16'h0000; hold_samples = 16'd3;
      cycle(1'b1, 1'b1, 1'b0, 16'h4000);
      chk("retrig_instant", env_level, 16'hFFFF);
      cycle(1'b1, 1'b0, 1'b1, 16'h4000);
      chk("retrig_hold", env_level, 16'hFFFF);

      cycle(1'b1, 1'b0, 1'b1, 16'h0123);
      cycle(1'b0, 1'b0, 1'b0, 16'h0123);
      chk("midrst_valid", sample_out_valid, 0);
      chk("midrst_out", sample_out, 16'h8000);
      chk("midrst_env", env_level, 0);
      chk("midrst_active", active, 0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0123);
      chk("midrst_valid2", sample_out_valid, 0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            attack_step = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            hold_samples = 16'($urandom_range(0, 5));
            decay_shift = 4'($urandom);
         end
         cycle(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 2) == 0), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
